// File: rtl/cpu_pkg.sv
// Shared opcode, step and control-word definitions for the hardwired sequencer.
// Optional macro CU_WAIT_STATE_EN is consumed by control_unit.
package cpu_pkg;

    localparam int OPW   = 5;
    localparam int STEPW = 3;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [STEPW-1:0] T0 = 3'd0;
    localparam logic [STEPW-1:0] T1 = 3'd1;
    localparam logic [STEPW-1:0] T2 = 3'd2;
    localparam logic [STEPW-1:0] T3 = 3'd3;
    localparam logic [STEPW-1:0] T4 = 3'd4;
    localparam logic [STEPW-1:0] T5 = 3'd5;
    localparam logic [STEPW-1:0] T6 = 3'd6;
    localparam logic [STEPW-1:0] T7 = 3'd7;

    // Bus drivers occupy bits 0..7 so a one-hot check is a simple slice.
    localparam int CW_PCOUT    = 0;
    localparam int CW_ZHIGHOUT = 1;
    localparam int CW_ZLOWOUT  = 2;
    localparam int CW_MDROUT   = 3;
    localparam int CW_HIOUT    = 4;
    localparam int CW_LOOUT    = 5;
    localparam int CW_COUT     = 6;
    localparam int CW_BAOUT    = 7;
    localparam int CW_PCIN     = 8;
    localparam int CW_ZIN      = 9;
    localparam int CW_MDRIN    = 10;
    localparam int CW_MARIN    = 11;
    localparam int CW_YIN      = 12;
    localparam int CW_HIIN     = 13;
    localparam int CW_LOIN     = 14;
    localparam int CW_IRIN     = 15;
    localparam int CW_CONIN    = 16;
    localparam int CW_GRA      = 17;
    localparam int CW_GRB      = 18;
    localparam int CW_GRC      = 19;
    localparam int CW_RIN      = 20;
    localparam int CW_ROUT     = 21;
    localparam int CW_INCPC    = 22;
    localparam int CW_READ     = 23;
    localparam int CW_WRITE    = 24;
    localparam int CW_ALU_LSB  = 25;
    localparam int CW_W        = 30;

    typedef enum logic [3:0] {
        CL_RR, CL_IMM, CL_UN, CL_MD, CL_LD, CL_LDI,
        CL_ST, CL_BR, CL_JR, CL_MF, CL_HALT, CL_NOP
    } opclass_t;

    function automatic opclass_t op_class(input logic [OPW-1:0] opc);
        opclass_t c;
        c = CL_NOP;
        case (opc) inside
            [OP_ADD:OP_ROL]:  c = CL_RR;
            [OP_ADDI:OP_ORI]: c = CL_IMM;
            OP_NEG, OP_NOT:   c = CL_UN;
            OP_MUL, OP_DIV:   c = CL_MD;
            OP_LD:            c = CL_LD;
            OP_LDI:           c = CL_LDI;
            OP_ST:            c = CL_ST;
            OP_BR:            c = CL_BR;
            OP_JR:            c = CL_JR;
            OP_MFHI, OP_MFLO: c = CL_MF;
            OP_HALT:          c = CL_HALT;
            default:          c = CL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational step x opcode decode into the datapath control word.
// Also flags the final step of a sequence and the halt request.
module control_decode
    import cpu_pkg::*;
(
    input  logic [STEPW-1:0] step_i,
    input  logic [OPW-1:0]   opc_i,
    input  logic             con_i,
    output logic [CW_W-1:0]  cw_o,
    output logic             last_o,
    output logic             halt_o
);

    opclass_t cls;
    assign cls = op_class(opc_i);

    always_comb begin
        cw_o   = '0;
        last_o = 1'b0;
        halt_o = 1'b0;
        if (step_i == T0) begin
            cw_o[CW_PCOUT] = 1'b1;
            cw_o[CW_MARIN] = 1'b1;
            cw_o[CW_INCPC] = 1'b1;
            cw_o[CW_ZIN]   = 1'b1;
        end else if (step_i == T1) begin
            cw_o[CW_ZLOWOUT] = 1'b1;
            cw_o[CW_PCIN]    = 1'b1;
            cw_o[CW_READ]    = 1'b1;
            cw_o[CW_MDRIN]   = 1'b1;
        end else if (step_i == T2) begin
            cw_o[CW_MDROUT] = 1'b1;
            cw_o[CW_IRIN]   = 1'b1;
        end else begin
            case (cls)
                CL_RR, CL_IMM: begin
                    case (step_i)
                        T3: begin
                            cw_o[CW_GRB]  = 1'b1;
                            cw_o[CW_ROUT] = 1'b1;
                            cw_o[CW_YIN]  = 1'b1;
                        end
                        T4: begin
                            if (cls == CL_IMM) begin
                                cw_o[CW_COUT] = 1'b1;
                            end else begin
                                cw_o[CW_GRC]  = 1'b1;
                                cw_o[CW_ROUT] = 1'b1;
                            end
                            cw_o[CW_ALU_LSB +: OPW] = opc_i;
                            cw_o[CW_ZIN] = 1'b1;
                        end
                        T5: begin
                            cw_o[CW_ZLOWOUT] = 1'b1;
                            cw_o[CW_GRA]     = 1'b1;
                            cw_o[CW_RIN]     = 1'b1;
                            last_o           = 1'b1;
                        end
                        default: ;
                    endcase
                end
                CL_UN: begin
                    if (step_i == T3) begin
                        cw_o[CW_GRB]  = 1'b1;
                        cw_o[CW_ROUT] = 1'b1;
                        cw_o[CW_ALU_LSB +: OPW] = opc_i;
                        cw_o[CW_ZIN]  = 1'b1;
                    end else if (step_i == T4) begin
                        cw_o[CW_ZLOWOUT] = 1'b1;
                        cw_o[CW_GRA]     = 1'b1;
                        cw_o[CW_RIN]     = 1'b1;
                        last_o           = 1'b1;
                    end
                end
                CL_MD: begin
                    case (step_i)
                        T3: begin
                            cw_o[CW_GRA]  = 1'b1;
                            cw_o[CW_ROUT] = 1'b1;
                            cw_o[CW_YIN]  = 1'b1;
                        end
                        T4: begin
                            cw_o[CW_GRB]  = 1'b1;
                            cw_o[CW_ROUT] = 1'b1;
                            cw_o[CW_ALU_LSB +: OPW] = opc_i;
                            cw_o[CW_ZIN]  = 1'b1;
                        end
                        T5: begin
                            cw_o[CW_ZLOWOUT] = 1'b1;
                            cw_o[CW_LOIN]    = 1'b1;
                        end
                        T6: begin
                            cw_o[CW_ZHIGHOUT] = 1'b1;
                            cw_o[CW_HIIN]     = 1'b1;
                            last_o            = 1'b1;
                        end
                        default: ;
                    endcase
                end
                CL_LD, CL_LDI, CL_ST: begin
                    case (step_i)
                        T3: begin
                            cw_o[CW_GRB]   = 1'b1;
                            cw_o[CW_BAOUT] = 1'b1;
                            cw_o[CW_YIN]   = 1'b1;
                        end
                        T4: begin
                            cw_o[CW_COUT] = 1'b1;
                            cw_o[CW_ALU_LSB +: OPW] = OP_ADD;
                            cw_o[CW_ZIN]  = 1'b1;
                        end
                        T5: begin
                            cw_o[CW_ZLOWOUT] = 1'b1;
                            if (cls == CL_LDI) begin
                                cw_o[CW_GRA] = 1'b1;
                                cw_o[CW_RIN] = 1'b1;
                                last_o       = 1'b1;
                            end else begin
                                cw_o[CW_MARIN] = 1'b1;
                            end
                        end
                        T6: begin
                            // st loads MDR from the bus, so Read stays low
                            cw_o[CW_MDRIN] = 1'b1;
                            if (cls == CL_ST) begin
                                cw_o[CW_GRA]  = 1'b1;
                                cw_o[CW_ROUT] = 1'b1;
                            end else begin
                                cw_o[CW_READ] = 1'b1;
                            end
                        end
                        T7: begin
                            last_o = 1'b1;
                            if (cls == CL_ST) begin
                                cw_o[CW_WRITE] = 1'b1;
                            end else begin
                                cw_o[CW_MDROUT] = 1'b1;
                                cw_o[CW_GRA]    = 1'b1;
                                cw_o[CW_RIN]    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                CL_BR: begin
                    case (step_i)
                        T3: begin
                            cw_o[CW_GRA]   = 1'b1;
                            cw_o[CW_ROUT]  = 1'b1;
                            cw_o[CW_CONIN] = 1'b1;
                        end
                        T4: begin
                            cw_o[CW_PCOUT] = 1'b1;
                            cw_o[CW_YIN]   = 1'b1;
                        end
                        T5: begin
                            cw_o[CW_COUT] = 1'b1;
                            cw_o[CW_ALU_LSB +: OPW] = OP_ADD;
                            cw_o[CW_ZIN]  = 1'b1;
                        end
                        T6: begin
                            cw_o[CW_ZLOWOUT] = 1'b1;
                            cw_o[CW_PCIN]    = con_i;
                            last_o           = 1'b1;
                        end
                        default: ;
                    endcase
                end
                CL_JR: begin
                    cw_o[CW_GRA]  = 1'b1;
                    cw_o[CW_ROUT] = 1'b1;
                    cw_o[CW_PCIN] = 1'b1;
                    last_o        = 1'b1;
                end
                CL_MF: begin
                    cw_o[CW_HIOUT] = (opc_i == OP_MFHI);
                    cw_o[CW_LOOUT] = (opc_i != OP_MFHI);
                    cw_o[CW_GRA]   = 1'b1;
                    cw_o[CW_RIN]   = 1'b1;
                    last_o         = 1'b1;
                end
                CL_HALT: begin
                    halt_o = 1'b1;
                    last_o = 1'b1;
                end
                default: last_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Step sequencer driving the datapath: holds step/halted and memory stalls.
// Define CU_WAIT_STATE_EN to stall Read/Write steps until Mem_ready.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Mem_ready,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        Zin,
    output logic        MDRin,
    output logic        MARin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IRin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    logic [STEPW-1:0] step_q, step_d;
    logic             halted_q, halted_d;
    logic [CW_W-1:0]  cw, ctrl;
    logic             last, halt, stall, live;
    logic             unused_ir;

    assign unused_ir = ^IR[26:0];

    control_decode u_dec (
        .step_i (step_q),
        .opc_i  (IR[31:27]),
        .con_i  (CON),
        .cw_o   (cw),
        .last_o (last),
        .halt_o (halt)
    );

`ifdef CU_WAIT_STATE_EN
    assign stall = (cw[CW_READ] | cw[CW_WRITE]) & ~Mem_ready;
`else
    logic unused_mem;
    assign unused_mem = Mem_ready;
    assign stall      = 1'b0;
`endif

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q && !stall) begin
            if (halt) begin
                halted_d = 1'b1;
            end
            if (last || step_q == T7) begin
                step_d = T0;
            end else begin
                step_d = step_q + STEPW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Reset is applied combinationally so outputs drop the instant it asserts.
    assign live = Reset_n & ~halted_q;
    assign ctrl = live ? cw : '0;
    assign Run  = live;

    assign PCout    = ctrl[CW_PCOUT];
    assign Zhighout = ctrl[CW_ZHIGHOUT];
    assign Zlowout  = ctrl[CW_ZLOWOUT];
    assign MDRout   = ctrl[CW_MDROUT];
    assign HIout    = ctrl[CW_HIOUT];
    assign LOout    = ctrl[CW_LOOUT];
    assign Cout     = ctrl[CW_COUT];
    assign BAout    = ctrl[CW_BAOUT];
    assign PCin     = ctrl[CW_PCIN];
    assign Zin      = ctrl[CW_ZIN];
    assign MDRin    = ctrl[CW_MDRIN];
    assign MARin    = ctrl[CW_MARIN];
    assign Yin      = ctrl[CW_YIN];
    assign HIin     = ctrl[CW_HIIN];
    assign LOin     = ctrl[CW_LOIN];
    assign IRin     = ctrl[CW_IRIN];
    assign CONin    = ctrl[CW_CONIN];
    assign Gra      = ctrl[CW_GRA];
    assign Grb      = ctrl[CW_GRB];
    assign Grc      = ctrl[CW_GRC];
    assign Rin      = ctrl[CW_RIN];
    assign Rout     = ctrl[CW_ROUT];
    assign IncPC    = ctrl[CW_INCPC];
    assign Read     = ctrl[CW_READ];
    assign Write    = ctrl[CW_WRITE];
    assign alu_op   = ctrl[CW_ALU_LSB +: OPW];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction table, random opcodes vs a
// sequence model, and hand-written reset / halt / wait-state sequences.
module tb_control_unit;

    typedef logic [29:0] cw_t;

    localparam cw_t PCOUT    = cw_t'(1) << 0;
    localparam cw_t ZHIGHOUT = cw_t'(1) << 1;
    localparam cw_t ZLOWOUT  = cw_t'(1) << 2;
    localparam cw_t MDROUT   = cw_t'(1) << 3;
    localparam cw_t HIOUT    = cw_t'(1) << 4;
    localparam cw_t LOOUT    = cw_t'(1) << 5;
    localparam cw_t COUT     = cw_t'(1) << 6;
    localparam cw_t BAOUT    = cw_t'(1) << 7;
    localparam cw_t PCIN     = cw_t'(1) << 8;
    localparam cw_t ZIN      = cw_t'(1) << 9;
    localparam cw_t MDRIN    = cw_t'(1) << 10;
    localparam cw_t MARIN    = cw_t'(1) << 11;
    localparam cw_t YIN      = cw_t'(1) << 12;
    localparam cw_t HIIN     = cw_t'(1) << 13;
    localparam cw_t LOIN     = cw_t'(1) << 14;
    localparam cw_t IRIN     = cw_t'(1) << 15;
    localparam cw_t CONIN    = cw_t'(1) << 16;
    localparam cw_t GRA      = cw_t'(1) << 17;
    localparam cw_t GRB      = cw_t'(1) << 18;
    localparam cw_t GRC      = cw_t'(1) << 19;
    localparam cw_t RIN      = cw_t'(1) << 20;
    localparam cw_t ROUT     = cw_t'(1) << 21;
    localparam cw_t INCPC    = cw_t'(1) << 22;
    localparam cw_t READ     = cw_t'(1) << 23;
    localparam cw_t WRITE    = cw_t'(1) << 24;

    localparam cw_t F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam cw_t F1 = ZLOWOUT | PCIN | READ | MDRIN;
    localparam cw_t F2 = MDROUT | IRIN;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] IR = '0;
    logic        CON = 1'b0;
    logic        Mem_ready = 1'b1;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout;
    logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run;
    logic [4:0] alu_op;
    cw_t obs;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON(CON),
        .Mem_ready(Mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .BAout(BAout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin),
        .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin),
        .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write),
        .alu_op(alu_op), .Run(Run)
    );

    assign obs = {alu_op, Write, Read, IncPC, Rout, Rin, Grc, Grb, Gra,
                  CONin, IRin, LOin, HIin, Yin, MARin, MDRin, Zin, PCin,
                  BAout, Cout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    int n_tests = 0;
    int n_fail  = 0;
    cw_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic cw_t alu(input logic [4:0] o);
        return cw_t'(o) << 25;
    endfunction

    // Expected control word per cycle, straight from the instruction tables.
    function automatic void model(input logic [31:0] ir, input logic con);
        logic [4:0] o;
        o = ir[31:27];
        exp_q.delete();
        exp_q.push_back(F0);
        exp_q.push_back(F1);
        exp_q.push_back(F2);
        if (o >= 5'd3 && o <= 5'd11) begin
            exp_q.push_back(GRB | ROUT | YIN);
            exp_q.push_back(GRC | ROUT | ZIN | alu(o));
            exp_q.push_back(ZLOWOUT | GRA | RIN);
        end else if (o >= 5'd12 && o <= 5'd14) begin
            exp_q.push_back(GRB | ROUT | YIN);
            exp_q.push_back(COUT | ZIN | alu(o));
            exp_q.push_back(ZLOWOUT | GRA | RIN);
        end else if (o == 5'd17 || o == 5'd18) begin
            exp_q.push_back(GRB | ROUT | ZIN | alu(o));
            exp_q.push_back(ZLOWOUT | GRA | RIN);
        end else if (o == 5'd15 || o == 5'd16) begin
            exp_q.push_back(GRA | ROUT | YIN);
            exp_q.push_back(GRB | ROUT | ZIN | alu(o));
            exp_q.push_back(ZLOWOUT | LOIN);
            exp_q.push_back(ZHIGHOUT | HIIN);
        end else if (o <= 5'd2) begin
            exp_q.push_back(GRB | BAOUT | YIN);
            exp_q.push_back(COUT | ZIN | alu(5'd3));
            if (o == 5'd1) begin
                exp_q.push_back(ZLOWOUT | GRA | RIN);
            end else if (o == 5'd0) begin
                exp_q.push_back(ZLOWOUT | MARIN);
                exp_q.push_back(READ | MDRIN);
                exp_q.push_back(MDROUT | GRA | RIN);
            end else begin
                exp_q.push_back(ZLOWOUT | MARIN);
                exp_q.push_back(GRA | ROUT | MDRIN);
                exp_q.push_back(WRITE);
            end
        end else if (o == 5'd19) begin
            exp_q.push_back(GRA | ROUT | CONIN);
            exp_q.push_back(PCOUT | YIN);
            exp_q.push_back(COUT | ZIN | alu(5'd3));
            exp_q.push_back(con ? (ZLOWOUT | PCIN) : ZLOWOUT);
        end else if (o == 5'd20) begin
            exp_q.push_back(GRA | ROUT | PCIN);
        end else if (o == 5'd24) begin
            exp_q.push_back(HIOUT | GRA | RIN);
        end else if (o == 5'd25) begin
            exp_q.push_back(LOOUT | GRA | RIN);
        end else begin
            exp_q.push_back('0);
        end
    endfunction

    task automatic inv(input string nm);
        chk({nm, " one bus driver"}, 32'($countones(obs[7:0]) <= 1), 32'd1);
        if (!obs[9]) chk({nm, " alu_op idle"}, 32'(obs[29:25]), 32'd0);
    endtask

    // Starts and ends on a negedge+1 with the DUT sitting at T0.
    task automatic run_instr(input string nm, input logic [31:0] ir,
                             input logic con, input int sidx, input int sn);
        bit is_halt;
        is_halt = (ir[31:27] == 5'b11011);
        IR  = ir;
        CON = con;
        model(ir, con);
        #1;
        foreach (exp_q[i]) begin
            if (i == sidx) begin
                Mem_ready = 1'b0;
                repeat (sn) begin
                    chk($sformatf("%s wait T%0d", nm, i), obs, exp_q[i]);
                    @(negedge Clock); #1;
                end
                Mem_ready = 1'b1;
                #1;
            end
            chk($sformatf("%s T%0d", nm, i), obs, exp_q[i]);
            inv(nm);
            @(negedge Clock); #1;
        end
        chk({nm, " end word"}, obs, is_halt ? '0 : F0);
        chk({nm, " end Run"}, 32'(Run), is_halt ? 32'd0 : 32'd1);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ir;
        logic        con;
        int          cyc;
        cw_t         last;
    } vec_t;

    vec_t tbl[13];

    task automatic measure(input vec_t v);
        int  cyc;
        cw_t prev;
        IR  = v.ir;
        CON = v.con;
        #1;
        cyc  = 0;
        prev = obs;
        do begin
            prev = obs;
            @(negedge Clock); #1;
            cyc++;
        end while (obs !== F0 && cyc < 12);
        chk({v.nm, " cycles"}, 32'(cyc), 32'(v.cyc));
        chk({v.nm, " last step"}, prev, v.last);
    endtask

    initial begin
        logic [4:0]  o;
        logic [31:0] ir;

        tbl[0]  = '{"shr",   32'h389A8000, 1'b0, 6, ZLOWOUT | GRA | RIN};
        tbl[1]  = '{"mul",   32'h78000000, 1'b0, 7, ZHIGHOUT | HIIN};
        tbl[2]  = '{"br c0", 32'h98000000, 1'b0, 7, ZLOWOUT};
        tbl[3]  = '{"br c1", 32'h98000000, 1'b1, 7, ZLOWOUT | PCIN};
        tbl[4]  = '{"jr",    32'hA0000000, 1'b0, 4, GRA | ROUT | PCIN};
        tbl[5]  = '{"ld",    32'h00800000, 1'b0, 8, MDROUT | GRA | RIN};
        tbl[6]  = '{"st",    32'h10000000, 1'b0, 8, WRITE};
        tbl[7]  = '{"ldi",   32'h08000000, 1'b0, 6, ZLOWOUT | GRA | RIN};
        tbl[8]  = '{"neg",   32'h88000000, 1'b0, 5, ZLOWOUT | GRA | RIN};
        tbl[9]  = '{"mflo",  32'hC8000000, 1'b0, 4, LOOUT | GRA | RIN};
        tbl[10] = '{"addi",  32'h60000000, 1'b0, 6, ZLOWOUT | GRA | RIN};
        tbl[11] = '{"undef", 32'hB0000000, 1'b0, 4, '0};
        tbl[12] = '{"nop",   32'hD0000000, 1'b0, 4, '0};

        repeat (3) @(negedge Clock);
        #1;
        chk("reset outputs", obs, '0);
        chk("reset Run", 32'(Run), 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("post-reset T0", obs, F0);
        chk("post-reset Run", 32'(Run), 32'd1);

        foreach (tbl[i]) begin
            measure(tbl[i]);
            run_instr(tbl[i].nm, tbl[i].ir, tbl[i].con, -1, 0);
        end

        for (int k = 0; k < 40; k++) begin
            do o = 5'($urandom_range(0, 31)); while (o == 5'b11011);
            ir = {o, 27'($urandom)};
            run_instr($sformatf("rnd%0d op%0d", k, o), ir, 1'($urandom), -1, 0);
        end

        // Reset asserted in the middle of T4 of shr.
        IR = 32'h389A8000;
        #1;
        repeat (4) @(negedge Clock);
        #1;
        chk("shr T4 before reset", obs, GRC | ROUT | ZIN | alu(5'b00111));
        Reset_n = 1'b0;
        #1;
        chk("mid reset outputs", obs, '0);
        chk("mid reset Run", 32'(Run), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        chk("after mid reset T0", obs, F0);
        chk("after mid reset Run", 32'(Run), 32'd1);
        run_instr("shr again", 32'h389A8000, 1'b0, -1, 0);

`ifdef CU_WAIT_STATE_EN
        run_instr("ld wait", 32'h00800000, 1'b0, 6, 3);
        run_instr("st wait", 32'h10000000, 1'b0, 7, 2);
        run_instr("fetch wait", 32'h389A8000, 1'b0, 1, 2);
`endif

        run_instr("halt", 32'hD8000000, 1'b0, -1, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock); #1;
            chk($sformatf("halted out c%0d", k), obs, '0);
            chk($sformatf("halted Run c%0d", k), 32'(Run), 32'd0);
        end
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        run_instr("nop after halt", 32'hD0000000, 1'b0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
